datamem_lsu: RTL
================

# datamem_lsu

Parametrised successor to the single-cycle word data memory. It sits in the MEM stage between the ALU address output and the write-back mux. It serves all RV32I loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero extension. Read latency is configurable, with a req/ready/valid handshake and misalignment/illegal-op detection. The write-back mux (ALU result vs load data) is no longer inside the memory; it moves to the core.

## Interface
- DATA_WIDTH, 32, data word width; byte-lane logic is defined for 32 only.
- ADDR_WIDTH, 12, byte-address bits decoded; depth = 2**(ADDR_WIDTH-2) words.
- LATENCY, 1, cycles from acceptance edge to `valid`; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-high.
- req  in  1  access request; accepted on a rising edge where `req && ready`.
- we  in  1  1 = store, 0 = load; sampled at acceptance.
- funct3  in  3  RV32I width/sign code; sampled at acceptance.
- addr  in  32  byte address; bits [31:ADDR_WIDTH] are ignored (wrap).
- wdata  in  DATA_WIDTH  store data, LSB-aligned.
- ready  out  1  block can accept a request this cycle.
- valid  out  1  one-cycle completion pulse.
- rdata  out  DATA_WIDTH  extended load result; 0 for stores and errors.
- error  out  1  qualifies `valid`: misaligned access or illegal funct3.

## Operation
- Storage: word array, index addr[ADDR_WIDTH-1:2], lane addr[1:0]; contents not reset.
- Load extension:
  - funct3 000 LB: byte sign-extended.
  - 001 LH: half sign-extended.
  - 010 LW: full word.
  - 100 LBU: byte zero-extended.
  - 101 LHU: half zero-extended.
- Store width: 000 SB, 001 SH, 010 SW. Only the addressed lanes are written, using the low bits of `wdata`; other lanes are unchanged.
- Error conditions:
  - half access with addr[0]=1.
  - word access with addr[1:0]!=0.
  - funct3 in {011,110,111}.
  - funct3 100/101 with we=1.
- On error: no write occurs, `valid`+`error` pulse on the normal completion cycle, rdata=0.
- FSM states: IDLE (ready=1) and WAIT (ready=0, down-counter).
  - IDLE + accept load, LATENCY=1: stay IDLE.
  - IDLE + accept load, LATENCY>1: go to WAIT with cnt=LATENCY-2.
  - WAIT: decrement each cycle; at cnt=0 return to IDLE, asserting valid on the following cycle.
  - Stores and errored accesses always stay in IDLE.
- Load data is the memory snapshot at the acceptance edge, so later stores cannot alter an outstanding load. Only one load is outstanding at a time.
- rdata holds its value until the next valid pulse; error likewise.

## Timing
- Reset values: ready=1, valid=0, rdata=0, error=0, FSM=IDLE, cnt=0.
- Reset asserted mid-load aborts the load: no valid is produced and memory is unaffected.
- Store: write commits at the acceptance edge. valid is high in the following cycle. ready stays 1, giving one store per cycle throughput.
- Load: valid is high exactly LATENCY cycles after the acceptance edge, for 1 cycle. ready is low in the intervening LATENCY-1 cycles and is 1 again in the valid cycle, so back-to-back loads issue every LATENCY cycles.
- A store accepted in a load's valid cycle writes at that edge; it does not affect the load's rdata.
- req while ready=0 is ignored; the requester must hold req.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 (LATENCY=1) -> valid one cycle after each accept; rdata=0xDEADBEEF, error=0.
- Byte/half extension: SB 0x80 @0x21, then:
  - LB @0x21 -> rdata=0xFFFFFF80.
  - LBU @0x21 -> rdata=0x00000080.
  - SH 0x8001 @0x22, then LW @0x20 -> rdata=0x800180xx, where the low byte is preserved from before.
- Misalignment: LW @0x13 and SH @0x15 -> valid+error=1, rdata=0. A subsequent LW @0x14 returns the unchanged prior word. funct3=011 also flags error.
- LATENCY=3: LW accepted at edge N -> ready=0 for cycles N+1..N+2, valid at N+3. A store issued during WAIT is held off until ready=1.
- Reset: assert rst one cycle after a LATENCY=3 load is accepted -> valid never pulses and outputs return to reset values. Post-reset loads return the pre-reset memory contents.
- Wrap: SW 0x12345678 @(0x1000 + 0x8) with ADDR_WIDTH=12 -> LW @0x8 returns 0x12345678.

Source files
------------

// File: rtl/datamem_lsu.sv
// -----------------------------------------------------------------------------
// datamem_lsu
//   MEM-stage load/store unit with a byte-addressed, word-organised data
//   memory. It handles all RV32I loads and stores: byte-lane writes,
//   sign/zero extension, misalignment and illegal-op detection, and a
//   configurable load latency behind a req/ready/valid handshake.
//
// Parameters
//   DATA_WIDTH  word width (byte-lane logic is defined for 32)
//   ADDR_WIDTH  byte-address bits decoded; depth = 2**(ADDR_WIDTH-2) words
//   LATENCY     cycles from acceptance edge to valid (1..4)
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous active-high reset
//   req     in   access request, accepted on an edge where req && ready
//   we      in   1 = store, 0 = load
//   funct3  in   RV32I width/sign code
//   addr    in   byte address; bits above ADDR_WIDTH-1 wrap
//   wdata   in   store data, LSB-aligned
//   ready   out  a request can be accepted this cycle
//   valid   out  one-cycle completion pulse
//   rdata   out  extended load data (0 for stores and errors), held
//   error   out  qualifies valid: misaligned or illegal access, held
// -----------------------------------------------------------------------------
module datamem_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  error
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [1:0] CNT_INIT = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state, next_state;
  logic [1:0] cnt, next_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-3:0] index;
  logic [1:0]            lane;
  logic                  addr_unused;

  logic                  accept;
  logic                  bad;
  logic                  mem_we;
  logic                  long_load;
  logic [LANES-1:0]      be;
  logic [DATA_WIDTH-1:0] wword;
  logic [DATA_WIDTH-1:0] word;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] ld;
  logic [DATA_WIDTH-1:0] result;
  logic [DATA_WIDTH-1:0] pend;

  assign index       = addr[ADDR_WIDTH-1:2];
  assign lane        = addr[1:0];
  // Upper address bits are deliberately dropped so addresses wrap.
  assign addr_unused = ^addr[31:ADDR_WIDTH];

  assign ready  = (state == S_IDLE);
  assign accept = req && ready;
  // Only a clean load takes the multi-cycle path; stores and errors finish
  // on the following cycle.
  assign long_load = !we && !bad && (LATENCY > 1);
  assign mem_we    = accept && we && !bad && !rst;

  // Decode legality, lane enables and the lane-replicated store data.
  always_comb begin
    bad   = 1'b0;
    be    = '0;
    wword = wdata;
    case (funct3)
      3'b000: begin
        be    = {{(LANES-1){1'b0}}, 1'b1} << lane;
        wword = {LANES{wdata[7:0]}};
      end
      3'b001: begin
        if (lane[0]) bad = 1'b1;
        else         be  = {{(LANES-2){1'b0}}, 2'b11} << lane;
        wword = {(LANES/2){wdata[15:0]}};
      end
      3'b010: begin
        if (lane != 2'b00) bad = 1'b1;
        else               be  = '1;
      end
      3'b100:  bad = we;
      3'b101:  bad = we || lane[0];
      default: bad = 1'b1;
    endcase
  end

  // Load path: pick the addressed byte/half out of the word and extend it.
  always_comb begin
    word     = mem[index];
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = word[{lane[1], 4'b0000} +: 16];
    ld       = '0;
    case (funct3)
      3'b000:  ld = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  ld = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b010:  ld = word;
      3'b100:  ld = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  ld = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: ld = '0;
    endcase
    result = (we || bad) ? '0 : ld;
  end

  // Storage is not reset; only the addressed lanes are written.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // WAIT counts down from LATENCY-2; leaving at zero lines valid up with
  // exactly LATENCY cycles after acceptance.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      S_IDLE: begin
        if (accept && long_load) begin
          next_state = S_WAIT;
          next_cnt   = CNT_INIT;
        end
      end
      S_WAIT: begin
        if (cnt == 2'd0) next_state = S_IDLE;
        else             next_cnt   = cnt - 2'd1;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Load data is snapshotted at acceptance so later stores cannot change it;
  // rdata/error only move when valid pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      rdata <= '0;
      error <= 1'b0;
      pend  <= '0;
    end else begin
      valid <= 1'b0;
      if (accept) begin
        if (long_load) begin
          pend <= result;
        end else begin
          valid <= 1'b1;
          rdata <= result;
          error <= bad;
        end
      end else if (state == S_WAIT && cnt == 2'd0) begin
        valid <= 1'b1;
        rdata <= pend;
        error <= 1'b0;
      end
    end
  end

endmodule
